// File: rtl/fight_health_ctrl_pkg.sv
// Shared types and the damage lookup for the two-player fight health/round controller.
package fight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_FIGHT    = 3'b001,
    ST_P1_RND   = 3'b010,
    ST_P2_RND   = 3'b011,
    ST_DRAW     = 3'b100,
    ST_P1_MATCH = 3'b101,
    ST_P2_MATCH = 3'b110
  } fight_state_e;

  localparam logic [1:0] ATK_NONE = 2'b00;
  localparam logic [1:0] ATK_L    = 2'b01;
  localparam logic [1:0] ATK_M    = 2'b10;
  localparam logic [1:0] ATK_H    = 2'b11;

  function automatic int unsigned atk_damage(input logic [1:0] atk,
                                             input int unsigned dmg_l,
                                             input int unsigned dmg_m,
                                             input int unsigned dmg_h);
    int unsigned d;
    case (atk)
      ATK_L:   d = dmg_l;
      ATK_M:   d = dmg_m;
      ATK_H:   d = dmg_h;
      default: d = 0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fight_health_ctrl_if.sv
// Hit/attack inputs and HUD-facing outputs of the fight health controller.
interface fight_health_ctrl_if #(
  parameter int unsigned HP_W   = 9,
  parameter int unsigned WINS_W = 2
);
  logic              start;
  logic              hit_p1;
  logic              hit_p2;
  logic [1:0]        atk_p1;
  logic [1:0]        atk_p2;
  logic              block_p1;
  logic              block_p2;
  logic [HP_W-1:0]   health_1;
  logic [HP_W-1:0]   health_2;
  logic              invuln_1;
  logic              invuln_2;
  logic [WINS_W-1:0] wins_1;
  logic [WINS_W-1:0] wins_2;
  logic [2:0]        state;

  modport master (
    output start, hit_p1, hit_p2, atk_p1, atk_p2, block_p1, block_p2,
    input  health_1, health_2, invuln_1, invuln_2, wins_1, wins_2, state
  );

  modport slave (
    input  start, hit_p1, hit_p2, atk_p1, atk_p2, block_p1, block_p2,
    output health_1, health_2, invuln_1, invuln_2, wins_1, wins_2, state
  );
endinterface

// File: rtl/fight_health_ch.sv
// One player's health channel: health register, iframe counter, saturating damage.
// Blocked-hit scaling is built only when FIGHT_BLOCK_EN is defined.
module fight_health_ch
  import fight_pkg::*;
#(
  parameter int unsigned HP_W       = 9,
  parameter int unsigned MAX_HP     = 400,
  parameter int unsigned DMG_L      = 4,
  parameter int unsigned DMG_M      = 10,
  parameter int unsigned DMG_H      = 20,
  parameter int unsigned IFRAME_CYC = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            fight,
  input  logic            tick,
  input  logic            hit,
  input  logic [1:0]      atk,
`ifdef FIGHT_BLOCK_EN
  input  logic            block,
`endif
  output logic [HP_W-1:0] health,
  output logic            invuln,
  output logic            zero_next
);

  localparam int unsigned IFR_W = $clog2(IFRAME_CYC + 2);

  logic [IFR_W-1:0] ifr;
  logic             take;
  logic             blocked;
  logic [31:0]      dmg;
  logic [31:0]      dmg_app;
  logic [HP_W-1:0]  health_nx;

  always_comb begin
    blocked = 1'b0;
`ifdef FIGHT_BLOCK_EN
    blocked = block;
`endif
    take    = fight && hit && (atk != ATK_NONE) && (ifr == '0);
    dmg     = atk_damage(atk, DMG_L, DMG_M, DMG_H);
    dmg_app = dmg;
    // A blocked hit still lands for at least one point
    if (blocked)
      dmg_app = ((dmg >> 2) == 32'd0) ? 32'd1 : (dmg >> 2);
    health_nx = health;
    if (take)
      health_nx = (dmg_app >= 32'(health)) ? '0 : health - HP_W'(dmg_app);
    zero_next = (health_nx == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      health <= '0;
      ifr    <= '0;
    end else if (load) begin
      health <= HP_W'(MAX_HP);
      ifr    <= '0;
    end else begin
      health <= health_nx;
      if (tick && ifr != '0)
        ifr <= ifr - 1'b1;
      else if (take && !blocked)
        ifr <= IFR_W'(IFRAME_CYC);
    end
  end

  assign invuln = (ifr != '0);

endmodule

// File: rtl/fight_health_ctrl.sv
// Two-player round/match controller: round FSM, KO hold timer and win counters.
// Optional macro FIGHT_BLOCK_EN enables reduced damage on blocked hits.
module fight_health_ctrl
  import fight_pkg::*;
#(
  parameter int unsigned HP_W          = 9,
  parameter int unsigned MAX_HP        = 400,
  parameter int unsigned DMG_L         = 4,
  parameter int unsigned DMG_M         = 10,
  parameter int unsigned DMG_H         = 20,
  parameter int unsigned IFRAME_CYC    = 30,
  parameter int unsigned KO_HOLD_CYC   = 120,
  parameter int unsigned WINS_W        = 2,
  parameter int unsigned ROUNDS_TO_WIN = 2
) (
  input  logic               clk,
  input  logic               reset,
  fight_health_ctrl_if.slave bus
);

  localparam int unsigned HOLD_W = $clog2(KO_HOLD_CYC + 2);

  fight_state_e      state_q;
  logic [HOLD_W-1:0] hold;
  logic [WINS_W-1:0] wins_1;
  logic [WINS_W-1:0] wins_2;
  logic              fight, round_end, match, p1_done, p2_done;
  logic              load, tick, zero_1, zero_2;

  always_comb begin
    fight     = (state_q == ST_FIGHT);
    round_end = (state_q == ST_P1_RND) || (state_q == ST_P2_RND) || (state_q == ST_DRAW);
    match     = (state_q == ST_P1_MATCH) || (state_q == ST_P2_MATCH);
    p1_done   = (32'(wins_1) >= 32'(ROUNDS_TO_WIN));
    p2_done   = (32'(wins_2) >= 32'(ROUNDS_TO_WIN));
    // Refill on a new match or when a hold expires without a match winner
    load      = ((state_q == ST_IDLE || match) && bus.start) ||
                (round_end && hold == '0 && !p1_done && !p2_done);
    tick      = fight || round_end;
  end

  fight_health_ch #(
    .HP_W(HP_W), .MAX_HP(MAX_HP), .DMG_L(DMG_L), .DMG_M(DMG_M),
    .DMG_H(DMG_H), .IFRAME_CYC(IFRAME_CYC)
  ) u_ch_1 (
    .clk(clk), .reset(reset), .load(load), .fight(fight), .tick(tick),
    .hit(bus.hit_p1), .atk(bus.atk_p2),
`ifdef FIGHT_BLOCK_EN
    .block(bus.block_p1),
`endif
    .health(bus.health_1), .invuln(bus.invuln_1), .zero_next(zero_1)
  );

  fight_health_ch #(
    .HP_W(HP_W), .MAX_HP(MAX_HP), .DMG_L(DMG_L), .DMG_M(DMG_M),
    .DMG_H(DMG_H), .IFRAME_CYC(IFRAME_CYC)
  ) u_ch_2 (
    .clk(clk), .reset(reset), .load(load), .fight(fight), .tick(tick),
    .hit(bus.hit_p2), .atk(bus.atk_p1),
`ifdef FIGHT_BLOCK_EN
    .block(bus.block_p2),
`endif
    .health(bus.health_2), .invuln(bus.invuln_2), .zero_next(zero_2)
  );

`ifndef FIGHT_BLOCK_EN
  logic unused_block;
  assign unused_block = bus.block_p1 ^ bus.block_p2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold    <= '0;
      wins_1  <= '0;
      wins_2  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_P1_MATCH, ST_P2_MATCH: begin
          if (bus.start) begin
            state_q <= ST_FIGHT;
            wins_1  <= '0;
            wins_2  <= '0;
          end
        end
        ST_FIGHT: begin
          if (zero_1 && zero_2) begin
            state_q <= ST_DRAW;
            hold    <= HOLD_W'(KO_HOLD_CYC - 1);
          end else if (zero_2) begin
            state_q <= ST_P1_RND;
            hold    <= HOLD_W'(KO_HOLD_CYC - 1);
            if (wins_1 != '1) wins_1 <= wins_1 + 1'b1;
          end else if (zero_1) begin
            state_q <= ST_P2_RND;
            hold    <= HOLD_W'(KO_HOLD_CYC - 1);
            if (wins_2 != '1) wins_2 <= wins_2 + 1'b1;
          end
        end
        ST_P1_RND, ST_P2_RND, ST_DRAW: begin
          if (hold == '0) begin
            if (p1_done)      state_q <= ST_P1_MATCH;
            else if (p2_done) state_q <= ST_P2_MATCH;
            else              state_q <= ST_FIGHT;
          end else begin
            hold <= hold - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.state  = state_q;
  assign bus.wins_1 = wins_1;
  assign bus.wins_2 = wins_2;

endmodule

// File: tb/tb_fight_health_ctrl.sv
// Self-checking bench for fight_health_ctrl: vector table, KO/draw/match sequences, random vs model.
module tb_fight_health_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fight_health_ctrl_if #(.HP_W(9), .WINS_W(2)) bus ();

  fight_health_ctrl #(
    .HP_W(9), .MAX_HP(400), .DMG_L(4), .DMG_M(10), .DMG_H(20),
    .IFRAME_CYC(30), .KO_HOLD_CYC(120), .WINS_W(2), .ROUNDS_TO_WIN(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_h1, m_h2, m_i1, m_i2, m_w1, m_w2, m_st, m_hold;

  typedef struct {
    bit       start, hit1, hit2;
    bit [1:0] atk1, atk2;
    int       h1, h2, inv1, inv2, st, w1, w2;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dmg_of(input int atk, input bit blk);
    int d;
    d = (atk == 1) ? 4 : (atk == 2) ? 10 : (atk == 3) ? 20 : 0;
    if (blk) d = (d / 4 < 1) ? 1 : d / 4;
    return d;
  endfunction

  task automatic model_step();
    bit t1, t2, b1, b2;
    int n1, n2;
    b1 = 1'b0; b2 = 1'b0;
`ifdef FIGHT_BLOCK_EN
    b1 = bus.block_p1; b2 = bus.block_p2;
`endif
    if (reset) begin
      m_h1 = 0; m_h2 = 0; m_i1 = 0; m_i2 = 0; m_w1 = 0; m_w2 = 0; m_st = 0; m_hold = 0;
    end else if (m_st == 0 || m_st == 5 || m_st == 6) begin
      if (bus.start) begin
        m_st = 1; m_h1 = 400; m_h2 = 400; m_i1 = 0; m_i2 = 0; m_w1 = 0; m_w2 = 0;
      end
    end else if (m_st == 1) begin
      t1 = bus.hit_p1 && bus.atk_p2 != 0 && m_i1 == 0;
      t2 = bus.hit_p2 && bus.atk_p1 != 0 && m_i2 == 0;
      n1 = t1 ? m_h1 - dmg_of(int'(bus.atk_p2), b1) : m_h1;
      n2 = t2 ? m_h2 - dmg_of(int'(bus.atk_p1), b2) : m_h2;
      m_h1 = (n1 < 0) ? 0 : n1;
      m_h2 = (n2 < 0) ? 0 : n2;
      m_i1 = (m_i1 > 0) ? m_i1 - 1 : (t1 && !b1) ? 30 : 0;
      m_i2 = (m_i2 > 0) ? m_i2 - 1 : (t2 && !b2) ? 30 : 0;
      if (m_h1 == 0 && m_h2 == 0) begin m_st = 4; m_hold = 119; end
      else if (m_h2 == 0) begin m_st = 2; m_hold = 119; m_w1 = (m_w1 < 3) ? m_w1 + 1 : 3; end
      else if (m_h1 == 0) begin m_st = 3; m_hold = 119; m_w2 = (m_w2 < 3) ? m_w2 + 1 : 3; end
    end else begin
      if (m_i1 > 0) m_i1--;
      if (m_i2 > 0) m_i2--;
      if (m_hold == 0) begin
        if (m_w1 >= 2)      m_st = 5;
        else if (m_w2 >= 2) m_st = 6;
        else begin m_st = 1; m_h1 = 400; m_h2 = 400; m_i1 = 0; m_i2 = 0; end
      end else m_hold--;
    end
  endtask

  // Advance one clock with the current inputs and compare everything with the model.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("health_1", int'(bus.health_1), m_h1);
    chk("health_2", int'(bus.health_2), m_h2);
    chk("invuln_1", int'(bus.invuln_1), (m_i1 != 0) ? 1 : 0);
    chk("invuln_2", int'(bus.invuln_2), (m_i2 != 0) ? 1 : 0);
    chk("wins_1", int'(bus.wins_1), m_w1);
    chk("wins_2", int'(bus.wins_2), m_w2);
    chk("state", int'(bus.state), m_st);
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.hit_p1 = 0; bus.hit_p2 = 0;
    bus.atk_p1 = 2'b00; bus.atk_p2 = 2'b00; bus.block_p1 = 0; bus.block_p2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; cycle(); cycle();
    reset = 0;
  endtask

  task automatic start_match();
    bus.start = 1; cycle(); bus.start = 0;
  endtask

  // Hit with the given levels, then wait out the 30-cycle iframe window.
  task automatic hit_and_wait(input bit on1, input bit on2, input bit [1:0] lvl);
    bus.hit_p1 = on1; bus.hit_p2 = on2;
    bus.atk_p2 = on1 ? lvl : 2'b00; bus.atk_p1 = on2 ? lvl : 2'b00;
    cycle();
    idle_inputs();
    repeat (30) cycle();
  endtask

  task automatic ko_single(input bit lvl_last_h);
    bus.hit_p2 = 1; bus.atk_p1 = lvl_last_h ? 2'b11 : 2'b01;
    cycle();
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();

    // start, hit1, hit2, atk1, atk2, h1, h2, inv1, inv2, st, w1, w2
    vecs[0] = '{1, 0, 0, 2'd0, 2'd0, 400, 400, 0, 0, 1, 0, 0};
    vecs[1] = '{0, 1, 0, 2'd0, 2'd0, 400, 400, 0, 0, 1, 0, 0};
    vecs[2] = '{0, 0, 1, 2'd3, 2'd0, 400, 380, 0, 1, 1, 0, 0};
    vecs[3] = '{0, 0, 1, 2'd3, 2'd0, 400, 380, 0, 1, 1, 0, 0};
    vecs[4] = '{0, 1, 0, 2'd0, 2'd2, 390, 380, 1, 1, 1, 0, 0};
    vecs[5] = '{0, 1, 1, 2'd1, 2'd1, 390, 380, 1, 1, 1, 0, 0};
    vecs[6] = '{1, 0, 0, 2'd0, 2'd0, 390, 380, 1, 1, 1, 0, 0};
    vecs[7] = '{0, 0, 0, 2'd0, 2'd0, 390, 380, 1, 1, 1, 0, 0};

    do_reset();
    chk("rst_state", int'(bus.state), 0);
    chk("rst_health_1", int'(bus.health_1), 0);
    chk("rst_wins_1", int'(bus.wins_1), 0);

    for (int i = 0; i < 8; i++) begin
      bus.start = vecs[i].start; bus.hit_p1 = vecs[i].hit1; bus.hit_p2 = vecs[i].hit2;
      bus.atk_p1 = vecs[i].atk1; bus.atk_p2 = vecs[i].atk2;
      cycle();
      chk($sformatf("vec%0d_h1", i), int'(bus.health_1), vecs[i].h1);
      chk($sformatf("vec%0d_h2", i), int'(bus.health_2), vecs[i].h2);
      chk($sformatf("vec%0d_inv1", i), int'(bus.invuln_1), vecs[i].inv1);
      chk($sformatf("vec%0d_inv2", i), int'(bus.invuln_2), vecs[i].inv2);
      chk($sformatf("vec%0d_state", i), int'(bus.state), vecs[i].st);
      chk($sformatf("vec%0d_w1", i), int'(bus.wins_1), vecs[i].w1);
      chk($sformatf("vec%0d_w2", i), int'(bus.wins_2), vecs[i].w2);
    end

    // Iframe window: H hit, ignored re-hit 10 cycles later, accepted hit 31 cycles later
    do_reset();
    start_match();
    bus.hit_p2 = 1; bus.atk_p1 = 2'b11; cycle(); idle_inputs();
    chk("iframe_first_hit", int'(bus.health_2), 380);
    for (int k = 1; k <= 29; k++) begin
      if (k == 10) begin bus.hit_p2 = 1; bus.atk_p1 = 2'b11; end
      cycle();
      idle_inputs();
    end
    chk("iframe_ignored_hit", int'(bus.health_2), 380);
    chk("iframe_still_high", int'(bus.invuln_2), 1);
    cycle();
    chk("iframe_expired", int'(bus.invuln_2), 0);
    hit_and_wait(0, 1, 2'b11);
    chk("iframe_second_hit", int'(bus.health_2), 360);

    // Saturating KO: 360 -> 20 -> 16 -> H hit clamps to 0
    repeat (17) hit_and_wait(0, 1, 2'b11);
    hit_and_wait(0, 1, 2'b01);
    chk("pre_ko_health", int'(bus.health_2), 16);
    ko_single(1'b1);
    chk("ko_health_2", int'(bus.health_2), 0);
    chk("ko_state", int'(bus.state), 2);
    chk("ko_wins_1", int'(bus.wins_1), 1);
    repeat (119) cycle();
    chk("ko_hold_state", int'(bus.state), 2);
    cycle();
    chk("refill_state", int'(bus.state), 1);
    chk("refill_h1", int'(bus.health_1), 400);
    chk("refill_h2", int'(bus.health_2), 400);

    // Draw: both to 4 via trades, then a simultaneous L trade
    repeat (19) hit_and_wait(1, 1, 2'b11);
    repeat (4) hit_and_wait(1, 1, 2'b01);
    chk("draw_pre_h1", int'(bus.health_1), 4);
    bus.hit_p1 = 1; bus.hit_p2 = 1; bus.atk_p1 = 2'b01; bus.atk_p2 = 2'b01;
    cycle(); idle_inputs();
    chk("draw_state", int'(bus.state), 4);
    chk("draw_h1", int'(bus.health_1), 0);
    chk("draw_wins_1", int'(bus.wins_1), 1);
    chk("draw_wins_2", int'(bus.wins_2), 0);
    repeat (120) cycle();
    chk("draw_refill_state", int'(bus.state), 1);
    chk("draw_refill_h2", int'(bus.health_2), 400);

    // Second P1 round win ends the match; state frozen until start
    repeat (19) hit_and_wait(0, 1, 2'b11);
    ko_single(1'b1);
    chk("match_ko_wins_1", int'(bus.wins_1), 2);
    repeat (120) cycle();
    chk("match_state", int'(bus.state), 5);
    repeat (500) cycle();
    chk("match_frozen_state", int'(bus.state), 5);
    chk("match_frozen_wins", int'(bus.wins_1), 2);
    start_match();
    chk("rematch_state", int'(bus.state), 1);
    chk("rematch_wins_1", int'(bus.wins_1), 0);
    chk("rematch_h1", int'(bus.health_1), 400);

    // Reset mid-hold, then mid-iframe
    repeat (19) hit_and_wait(0, 1, 2'b11);
    ko_single(1'b1);
    repeat (50) cycle();
    reset = 1; cycle(); reset = 0;
    chk("rst_hold_state", int'(bus.state), 0);
    chk("rst_hold_wins", int'(bus.wins_1), 0);
    chk("rst_hold_h2", int'(bus.health_2), 0);
    start_match();
    bus.hit_p1 = 1; bus.atk_p2 = 2'b10; cycle(); idle_inputs();
    repeat (5) cycle();
    reset = 1; cycle(); reset = 0;
    chk("rst_iframe_inv1", int'(bus.invuln_1), 0);
    chk("rst_iframe_h1", int'(bus.health_1), 0);

`ifdef FIGHT_BLOCK_EN
    start_match();
    bus.hit_p1 = 1; bus.atk_p2 = 2'b10; bus.block_p1 = 1; cycle(); idle_inputs();
    chk("block_health", int'(bus.health_1), 398);
    chk("block_no_iframe", int'(bus.invuln_1), 0);
    do_reset();
`endif

    // Random traffic against the model
    start_match();
    for (int n = 0; n < 4000; n++) begin
      bus.start    = ($urandom_range(63) == 0);
      bus.hit_p1   = $urandom_range(1);
      bus.hit_p2   = $urandom_range(1);
      bus.atk_p1   = 2'($urandom_range(3));
      bus.atk_p2   = 2'($urandom_range(3));
      bus.block_p1 = $urandom_range(1);
      bus.block_p2 = $urandom_range(1);
      reset        = ($urandom_range(1999) == 0);
      cycle();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
